sqd_serializer: RTL

Parallel-to-serial front end for the bit sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on X_OUT, which drives the detector's serial input X directly. A one-word holding buffer lets consecutive words stream with no idle bit between them, so patterns that span word boundaries are still detected.

---
 rtl/sqd_pkg.sv | 25 ++
 rtl/sqd_shift_reg.sv | 56 +++++
 rtl/sqd_serializer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sqd_pkg.sv
// ============================================================================
// Module   : sqd_pkg
// Brief    : Shared types and helpers for the sequence detector and serializer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sqd_pkg;

    localparam int SQD_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } sqd_state_t;

    // Bit-index counter width; never narrower than one bit.
    function automatic int sqd_cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sqd_shift_reg.sv
// ============================================================================
// Module   : sqd_shift_reg
// Brief    : Loadable left-shift register with bit counter and last-bit flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sqd_shift_reg
    import sqd_pkg::*;
#(
    parameter int WIDTH = SQD_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             next_bit,
    output logic             last,
    output logic             near_last,
    output logic             word_parity
);

    localparam int            CW       = sqd_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] NEAR_IDX = CW'(WIDTH - 2);

    // The MSB goes straight to the output register on load, so only the
    // remaining WIDTH-1 bits are kept here.
    logic [WIDTH-2:0] rest;
    logic [CW-1:0]    cnt;
    logic             par;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rest <= '0;
            cnt  <= '0;
            par  <= 1'b0;
        end else if (load) begin
            rest <= load_data[WIDTH-2:0];
            cnt  <= '0;
            par  <= ^load_data;
        end else if (shift_en) begin
            rest <= rest << 1;
            cnt  <= cnt + 1'b1;
        end
    end

    assign next_bit    = rest[WIDTH-2];
    assign last        = (cnt == LAST_IDX);
    assign near_last   = (cnt == NEAR_IDX);
    assign word_parity = par;

endmodule

`default_nettype wire

// File: rtl/sqd_serializer.sv
// ============================================================================
// Module   : sqd_serializer
// Brief    : MSB-first parallel-to-serial front end with one-word holding
//            buffer. Define SQD_SER_PARITY_EN to append an even-parity bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sqd_serializer
    import sqd_pkg::*;
#(
    parameter int   WIDTH    = SQD_DEFAULT_WIDTH,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             word_done,
    output logic             busy
);

`ifdef SQD_SER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    sqd_state_t       state;
    sqd_state_t       state_nxt;
    logic             hold_full;
    logic [WIDTH-1:0] hold_word;

    logic             accept;
    logic             final_edge;
    logic             load;
    logic             load_hold;
    logic             hold_wr;
    logic             shift_en;
    logic             enter_parity;
    logic [WIDTH-1:0] load_data;
    logic             x_out_nxt;
    logic             x_valid_nxt;
    logic             word_done_nxt;

    logic             next_bit;
    logic             last;
    logic             near_last;
    logic             word_parity;

    assign din_ready  = reset && !hold_full;
    assign accept     = din_valid && din_ready;
    assign busy       = (state != ST_IDLE) || hold_full;
    assign final_edge = PARITY_EN ? (state == ST_PARITY)
                                  : ((state == ST_SHIFT) && last);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last) begin
                    if (PARITY_EN)                  state_nxt = ST_PARITY;
                    else if (!(hold_full || accept)) state_nxt = ST_IDLE;
                end
            end
            ST_PARITY: begin
                state_nxt = (hold_full || accept) ? ST_SHIFT : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Accepts never coincide with a hold-to-shifter move: din_ready is low
    // whenever the holding register is full.
    always_comb begin
        load_hold     = final_edge && hold_full;
        load          = load_hold || (accept && ((state == ST_IDLE) || final_edge));
        hold_wr       = accept && !load;
        load_data     = load_hold ? hold_word : din;
        shift_en      = (state == ST_SHIFT) && !last;
        enter_parity  = PARITY_EN && (state == ST_SHIFT) && last;
        x_out_nxt     = IDLE_BIT;
        x_valid_nxt   = 1'b0;
        word_done_nxt = 1'b0;
        if (load) begin
            x_out_nxt   = load_data[WIDTH-1];
            x_valid_nxt = 1'b1;
        end else if (shift_en) begin
            x_out_nxt     = next_bit;
            x_valid_nxt   = 1'b1;
            word_done_nxt = !PARITY_EN && near_last;
        end else if (enter_parity) begin
            x_out_nxt     = word_parity;
            x_valid_nxt   = 1'b1;
            word_done_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x_out     <= IDLE_BIT;
            x_valid   <= 1'b0;
            word_done <= 1'b0;
            hold_full <= 1'b0;
            hold_word <= '0;
        end else begin
            x_out     <= x_out_nxt;
            x_valid   <= x_valid_nxt;
            word_done <= word_done_nxt;
            if (load_hold) begin
                hold_full <= 1'b0;
            end else if (hold_wr) begin
                hold_full <= 1'b1;
                hold_word <= din;
            end
        end
    end

    sqd_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shift_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_data  (load_data),
        .shift_en   (shift_en),
        .next_bit   (next_bit),
        .last       (last),
        .near_last  (near_last),
        .word_parity(word_parity)
    );

endmodule

`default_nettype wire
